// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small transmit FIFO and runtime frame format.
// Baud divisor, data-bit count (5..8), parity (none/even/odd) and stop-bit
// count are sampled when a byte is popped, so each frame is self-consistent
// even if the configuration changes while it is on the line.
//
// Input handshake: a byte is written into the FIFO on every rising clk edge
// where s_valid && s_ready. s_ready is !full of the registered level only, so
// a pop on the same edge never makes room for a push into a full FIFO. The
// producer may change s_data only after an accepting edge, or while
// s_valid is low.

module uart_tx_fifo #(
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DIV_W-1:0]              baud_div,
  input  logic [1:0]                    cfg_data_bits,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_stop2,
  input  logic                          s_valid,
  input  logic [7:0]                    s_data,
  output logic                          s_ready,
  output logic                          tx,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // ---------------------------------------------------------------- FIFO
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level_q;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [7:0]    fifo_head;

  assign full      = (level_q == LW'(FIFO_DEPTH));
  assign empty     = (level_q == '0);
  assign push      = s_valid && !full;
  assign fifo_head = mem[rd_ptr];

  // Storage array: written on accepted pushes, contents need no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  // Pointers and occupancy; a simultaneous push and pop leaves the level alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // ---------------------------------------------------------------- FSM
  state_t           state_q, state_d;
  logic             tx_q, tx_d;
  logic [DIV_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic             stop_cnt_q, stop_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_q, par_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       bits_q, bits_d;
  logic [1:0]       parity_q, parity_d;
  logic             stop2_q, stop2_d;
  logic             load;

  logic             bit_end;
  logic             last_data;
  logic             par_en;

  assign bit_end   = (baud_cnt_q == div_q);
  assign last_data = (bit_cnt_q == ({1'b0, bits_q} + 3'd4));
  assign par_en    = (parity_q == 2'b01) || (parity_q == 2'b10);

  // State and frame registers; reset forces the line idle immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      tx_q       <= 1'b1;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      div_q      <= '0;
      bits_q     <= '0;
      parity_q   <= '0;
      stop2_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      div_q      <= div_d;
      bits_q     <= bits_d;
      parity_q   <= parity_d;
      stop2_q    <= stop2_d;
    end
  end

  // Next-state and next-tx; tx_d is the value the line takes for the next bit.
  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    div_d      = div_q;
    bits_d     = bits_q;
    parity_d   = parity_q;
    stop2_d    = stop2_q;
    load       = 1'b0;

    case (state_q)
      S_IDLE: begin
        tx_d       = 1'b1;
        baud_cnt_d = '0;
        if (!empty) load = 1'b1;
      end
      S_START: begin
        if (bit_end) begin
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
          par_d      = 1'b0;
          tx_d       = shift_q[0];
          state_d    = S_DATA;
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_cnt_d = '0;
          par_d      = par_q ^ shift_q[0];
          shift_d    = {1'b0, shift_q[7:1]};
          if (last_data) begin
            stop_cnt_d = 1'b0;
            if (par_en) begin
              tx_d    = par_q ^ shift_q[0] ^ (parity_q == 2'b10);
              state_d = S_PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = S_STOP;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            tx_d      = shift_q[1];
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          baud_cnt_d = '0;
          stop_cnt_d = 1'b0;
          tx_d       = 1'b1;
          state_d    = S_STOP;
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          baud_cnt_d = '0;
          if (stop2_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
            tx_d       = 1'b1;
          end else if (!empty) begin
            load = 1'b1;
          end else begin
            tx_d    = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 1'b1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase

    // Starting a frame: take the FIFO head and freeze the frame format.
    if (load) begin
      shift_d    = fifo_head;
      div_d      = baud_div;
      bits_d     = cfg_data_bits;
      parity_d   = cfg_parity;
      stop2_d    = cfg_stop2;
      baud_cnt_d = '0;
      tx_d       = 1'b0;
      state_d    = S_START;
    end
  end

  assign pop        = load;
  assign s_ready    = !full;
  assign tx         = tx_q;
  assign tx_busy    = (state_q != S_IDLE);
  assign fifo_level = level_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed testbench for uart_tx_fifo: frame shapes, parity, FIFO
// back-pressure, back-to-back frames, async reset and latched baud divisor.

module tb_uart_tx_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] baud_div;
  logic [1:0]  cfg_data_bits;
  logic [1:0]  cfg_parity;
  logic        cfg_stop2;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        tx;
  logic        tx_busy;
  logic [2:0]  fifo_level;

  int vectors     = 0;
  int miscompares = 0;

  logic [0:0] exp_q[$];
  logic [0:0] cap_tx[$];
  logic [0:0] cap_busy[$];
  logic [0:0] cap_rdy[$];
  logic [2:0] cap_lvl[$];

  uart_tx_fifo #(.DIV_W(16), .FIFO_DEPTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .baud_div      (baud_div),
    .cfg_data_bits (cfg_data_bits),
    .cfg_parity    (cfg_parity),
    .cfg_stop2     (cfg_stop2),
    .s_valid       (s_valid),
    .s_data        (s_data),
    .s_ready       (s_ready),
    .tx            (tx),
    .tx_busy       (tx_busy),
    .fifo_level    (fifo_level)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  // Expected line samples (one per clock) for one frame.
  task automatic build_frame(input logic [7:0] b, input int nbits, input int par,
                             input bit stop2, input int div);
    logic [0:0] bits[$];
    logic       p;
    p = 1'b0;
    bits.push_back(1'b0);
    for (int i = 0; i < nbits; i++) begin
      bits.push_back(b[i]);
      p = p ^ b[i];
    end
    if (par == 1) bits.push_back(p);
    else if (par == 2) bits.push_back(~p);
    bits.push_back(1'b1);
    if (stop2) bits.push_back(1'b1);
    foreach (bits[j]) repeat (div + 1) exp_q.push_back(bits[j]);
  endtask

  // Samples tx/tx_busy at n consecutive falling edges, starting now.
  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      cap_tx.push_back(tx);
      cap_busy.push_back(tx_busy);
      @(negedge clk);
    end
  endtask

  task automatic clear_queues();
    exp_q.delete();
    cap_tx.delete();
    cap_busy.delete();
    cap_rdy.delete();
    cap_lvl.delete();
  endtask

  // Driver tasks / tests
  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL reset_tx got %b exp 1", tx); end
    vectors++; if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b exp 0", tx_busy); end
    vectors++; if (fifo_level !== 3'd0) begin miscompares++; $display("FAIL reset_level got %0d exp 0", fifo_level); end
    vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b exp 1", s_ready); end
    rst = 1'b0;
    @(negedge clk);
    vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL post_reset_tx got %b exp 1", tx); end
    vectors++; if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL post_reset_busy got %b exp 0", tx_busy); end
  endtask

  task automatic test_8n1();
    clear_queues();
    baud_div = 16'd3; cfg_data_bits = 2'd3; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    build_frame(8'hA5, 8, 0, 1'b0, 3);
    s_valid = 1'b1; s_data = 8'hA5;
    vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("FAIL 8n1_ready got %b exp 1", s_ready); end
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL 8n1_latency_tx got %b exp 1", tx); end
    vectors++; if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL 8n1_latency_busy got %b exp 0", tx_busy); end
    vectors++; if (fifo_level !== 3'd1) begin miscompares++; $display("FAIL 8n1_level got %0d exp 1", fifo_level); end
    @(negedge clk);
    capture(40);
    vectors++; if (exp_q.size() != 40) begin miscompares++; $display("FAIL 8n1_len got %0d exp 40", exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (cap_tx[i] !== exp_q[i]) begin miscompares++; $display("FAIL 8n1_tx[%0d] got %b exp %b", i, cap_tx[i], exp_q[i]); end
      vectors++;
      if (cap_busy[i] !== 1'b1) begin miscompares++; $display("FAIL 8n1_busy[%0d] got %b exp 1", i, cap_busy[i]); end
    end
    vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL 8n1_end_tx got %b exp 1", tx); end
    vectors++; if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL 8n1_end_busy got %b exp 0", tx_busy); end
    vectors++; if (fifo_level !== 3'd0) begin miscompares++; $display("FAIL 8n1_end_level got %0d exp 0", fifo_level); end
  endtask

  task automatic test_7e2();
    clear_queues();
    baud_div = 16'd1; cfg_data_bits = 2'd2; cfg_parity = 2'b01; cfg_stop2 = 1'b1;
    build_frame(8'h55, 7, 1, 1'b1, 1);
    s_valid = 1'b1; s_data = 8'h55;
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL 7e2_latency_tx got %b exp 1", tx); end
    @(negedge clk);
    capture(22);
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (cap_tx[i] !== exp_q[i]) begin miscompares++; $display("FAIL 7e2_tx[%0d] got %b exp %b", i, cap_tx[i], exp_q[i]); end
    end
    vectors++; if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL 7e2_end_busy got %b exp 0", tx_busy); end
  endtask

  task automatic test_5o1();
    clear_queues();
    baud_div = 16'd1; cfg_data_bits = 2'd0; cfg_parity = 2'b10; cfg_stop2 = 1'b0;
    build_frame(8'hFF, 5, 2, 1'b0, 1);
    build_frame(8'h1F, 5, 2, 1'b0, 1);
    s_valid = 1'b1; s_data = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    s_data = 8'h1F;
    vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("FAIL 5o1_ready got %b exp 1", s_ready); end
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    vectors++; if (fifo_level !== 3'd1) begin miscompares++; $display("FAIL 5o1_level got %0d exp 1", fifo_level); end
    capture(32);
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (cap_tx[i] !== exp_q[i]) begin miscompares++; $display("FAIL 5o1_tx[%0d] got %b exp %b", i, cap_tx[i], exp_q[i]); end
    end
    vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL 5o1_end_tx got %b exp 1", tx); end
    vectors++; if (fifo_level !== 3'd0) begin miscompares++; $display("FAIL 5o1_end_level got %0d exp 0", fifo_level); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [6];
    int         k;
    logic       acc;
    clear_queues();
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
    bytes[3] = 8'h44; bytes[4] = 8'h55; bytes[5] = 8'h66;
    baud_div = 16'd0; cfg_data_bits = 2'd3; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    for (int b = 0; b < 6; b++) build_frame(bytes[b], 8, 0, 1'b0, 0);
    k = 0;
    for (int cyc = 0; cyc < 63; cyc++) begin
      cap_tx.push_back(tx);
      cap_busy.push_back(tx_busy);
      cap_rdy.push_back(s_ready);
      cap_lvl.push_back(fifo_level);
      if (k < 6) begin
        s_valid = 1'b1; s_data = bytes[k]; acc = s_ready;
      end else begin
        s_valid = 1'b0; acc = 1'b0;
      end
      @(posedge clk);
      if (acc) k++;
      @(negedge clk);
    end
    s_valid = 1'b0;
    vectors++; if (k != 6) begin miscompares++; $display("FAIL b2b_accepted got %0d exp 6", k); end
    vectors++; if (cap_lvl[5] !== 3'd4) begin miscompares++; $display("FAIL b2b_full_level got %0d exp 4", cap_lvl[5]); end
    vectors++; if (cap_rdy[5] !== 1'b0) begin miscompares++; $display("FAIL b2b_full_ready got %b exp 0", cap_rdy[5]); end
    vectors++; if (cap_rdy[11] !== 1'b0) begin miscompares++; $display("FAIL b2b_hold_ready got %b exp 0", cap_rdy[11]); end
    vectors++; if (cap_lvl[12] !== 3'd3) begin miscompares++; $display("FAIL b2b_pop_level got %0d exp 3", cap_lvl[12]); end
    vectors++; if (cap_rdy[12] !== 1'b1) begin miscompares++; $display("FAIL b2b_pop_ready got %b exp 1", cap_rdy[12]); end
    vectors++; if (cap_lvl[13] !== 3'd4) begin miscompares++; $display("FAIL b2b_refill_level got %0d exp 4", cap_lvl[13]); end
    vectors++; if (cap_tx[1] !== 1'b1) begin miscompares++; $display("FAIL b2b_pre_tx got %b exp 1", cap_tx[1]); end
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (cap_tx[i+2] !== exp_q[i]) begin miscompares++; $display("FAIL b2b_tx[%0d] got %b exp %b", i, cap_tx[i+2], exp_q[i]); end
    end
    vectors++; if (cap_tx[62] !== 1'b1) begin miscompares++; $display("FAIL b2b_end_tx got %b exp 1", cap_tx[62]); end
    vectors++; if (cap_busy[62] !== 1'b0) begin miscompares++; $display("FAIL b2b_end_busy got %b exp 0", cap_busy[62]); end
    vectors++; if (cap_lvl[62] !== 3'd0) begin miscompares++; $display("FAIL b2b_end_level got %0d exp 0", cap_lvl[62]); end
  endtask

  task automatic test_reset_mid_frame();
    clear_queues();
    baud_div = 16'd3; cfg_data_bits = 2'd3; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    s_valid = 1'b1; s_data = 8'h80;
    @(posedge clk); @(negedge clk);
    s_data = 8'h42;
    @(posedge clk); @(negedge clk);
    s_data = 8'h24;
    @(posedge clk); @(negedge clk);
    s_valid = 1'b0;
    repeat (5) @(negedge clk);
    vectors++; if (tx !== 1'b0) begin miscompares++; $display("FAIL rstmid_pre_tx got %b exp 0", tx); end
    vectors++; if (fifo_level !== 3'd2) begin miscompares++; $display("FAIL rstmid_pre_level got %0d exp 2", fifo_level); end
    rst = 1'b1;
    #1;
    vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL rstmid_tx got %b exp 1", tx); end
    vectors++; if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy got %b exp 0", tx_busy); end
    vectors++; if (fifo_level !== 3'd0) begin miscompares++; $display("FAIL rstmid_level got %0d exp 0", fifo_level); end
    vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("FAIL rstmid_ready got %b exp 1", s_ready); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL rstmid_rel_tx got %b exp 1", tx); end
    vectors++; if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_rel_busy got %b exp 0", tx_busy); end
    build_frame(8'h3C, 8, 0, 1'b0, 3);
    s_valid = 1'b1; s_data = 8'h3C;
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    @(negedge clk);
    capture(40);
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (cap_tx[i] !== exp_q[i]) begin miscompares++; $display("FAIL rstmid_tx[%0d] got %b exp %b", i, cap_tx[i], exp_q[i]); end
    end
    repeat (4) @(negedge clk);
    vectors++; if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_end_busy got %b exp 0", tx_busy); end
    vectors++; if (fifo_level !== 3'd0) begin miscompares++; $display("FAIL rstmid_end_level got %0d exp 0", fifo_level); end
  endtask

  task automatic test_baud_change();
    clear_queues();
    baud_div = 16'd3; cfg_data_bits = 2'd3; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    build_frame(8'h0F, 8, 0, 1'b0, 3);
    build_frame(8'hF0, 8, 0, 1'b0, 7);
    s_valid = 1'b1; s_data = 8'h0F;
    @(posedge clk); @(negedge clk);
    s_data = 8'hF0;
    @(posedge clk); @(negedge clk);
    s_valid = 1'b0;
    capture(10);
    baud_div = 16'd7;
    capture(110);
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (cap_tx[i] !== exp_q[i]) begin miscompares++; $display("FAIL baud_tx[%0d] got %b exp %b", i, cap_tx[i], exp_q[i]); end
    end
    vectors++; if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL baud_end_busy got %b exp 0", tx_busy); end
    vectors++; if (tx !== 1'b1) begin miscompares++; $display("FAIL baud_end_tx got %b exp 1", tx); end
  endtask

  // Test sequence and final report
  initial begin
    rst = 1'b1;
    baud_div = 16'd3;
    cfg_data_bits = 2'd3;
    cfg_parity = 2'b00;
    cfg_stop2 = 1'b0;
    s_valid = 1'b0;
    s_data = 8'h00;
    test_reset();
    test_8n1();
    test_7e2();
    test_5o1();
    test_back_to_back();
    test_reset_mid_frame();
    test_baud_change();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
